// File: rtl/glb_rd_arbiter_pkg.sv
// Shared types and constants for the GLB read-port arbiter.
// The requester indices follow the PE-array router order.
package glb_rd_arbiter_pkg;

  localparam int NUM_REQ_DEF  = 3;
  localparam int DATA_BW_DEF  = 16;
  localparam int ADDR_BW_DEF  = 10;
  localparam int LEN_BW_DEF   = 7;

  localparam int REQ_IACT = 0;
  localparam int REQ_WGHT = 1;
  localparam int REQ_PSUM = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glb_rd_arbiter_if.sv
// Bundle of the requester-side burst bus and the GLB read port.
// The slave modport is the arbiter's view, the master modport is the environment's.
interface glb_rd_arbiter_if
  import glb_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = NUM_REQ_DEF,
  parameter int DATA_BITWIDTH     = DATA_BW_DEF,
  parameter int ADDR_BITWIDTH_GLB = ADDR_BW_DEF,
  parameter int LEN_BITWIDTH      = LEN_BW_DEF
);
  logic [NUM_REQ-1:0]                   req;
  logic [NUM_REQ*ADDR_BITWIDTH_GLB-1:0] req_addr;
  logic [NUM_REQ*LEN_BITWIDTH-1:0]      req_len;
  logic [NUM_REQ-1:0]                   grant;
  logic [ADDR_BITWIDTH_GLB-1:0]         glb_r_addr;
  logic                                 glb_read_req;
  logic [DATA_BITWIDTH-1:0]             glb_r_data;
  logic [DATA_BITWIDTH-1:0]             rd_data;
  logic [NUM_REQ-1:0]                   rd_valid;
  logic [NUM_REQ-1:0]                   done;

  modport slave (
    input  req, req_addr, req_len, glb_r_data,
    output grant, glb_r_addr, glb_read_req, rd_data, rd_valid, done
  );

  modport master (
    output req, req_addr, req_len, glb_r_data,
    input  grant, glb_r_addr, glb_read_req, rd_data, rd_valid, done
  );
endinterface

// File: rtl/glb_rd_arbiter_pick.sv
// Combinational round-robin pick: first set request scanning upward from rr_ptr with wrap.
module rr_arbiter_pick
  import glb_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = ptr_w(NUM_REQ_DEF)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               found
);

  always_comb begin
    int pos;
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == pos)) begin
          winner[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/glb_rd_arbiter.sv
// Round-robin owner of the GLB read port: issues one burst per grant and steers
// the one-cycle-late read data back to the owner with valid and done strobes.
module glb_rd_arbiter
  import glb_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = NUM_REQ_DEF,
  parameter int DATA_BITWIDTH     = DATA_BW_DEF,
  parameter int ADDR_BITWIDTH_GLB = ADDR_BW_DEF,
  parameter int LEN_BITWIDTH      = LEN_BW_DEF
) (
  input logic              clk,
  input logic              reset,
  glb_rd_arbiter_if.slave  bus
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  state_e                       state_q, state_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]             owner_q, owner_d;
  logic [NUM_REQ-1:0]           grant_q, grant_d;
  logic [ADDR_BITWIDTH_GLB-1:0] addr_q, addr_d;
  logic                         read_req_q, read_req_d;
  logic [LEN_BITWIDTH-1:0]      len_q, len_d;
  logic [LEN_BITWIDTH-1:0]      cnt_q, cnt_d;
  logic                         pend_q, pend_d;
  logic [NUM_REQ-1:0]           pend_grant_q, pend_grant_d;
  logic [DATA_BITWIDTH-1:0]     rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]           rd_valid_q, rd_valid_d;
  logic [NUM_REQ-1:0]           done_q, done_d;

  logic [NUM_REQ-1:0]           win_onehot;
  logic                         win_found;
  logic [PTR_W-1:0]             win_idx;
  logic [ADDR_BITWIDTH_GLB-1:0] win_addr;
  logic [LEN_BITWIDTH-1:0]      win_len;

  rr_arbiter_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (win_onehot),
    .found  (win_found)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_idx  = PTR_W'(i);
        win_addr = bus.req_addr[i*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
        win_len  = bus.req_len[i*LEN_BITWIDTH +: LEN_BITWIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    read_req_d   = read_req_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    done_d       = '0;
    // Return path: data lands one cycle after the read, registered once more here.
    pend_d       = read_req_q;
    pend_grant_d = grant_q;
    rd_valid_d   = pend_q ? pend_grant_q : '0;
    rd_data_d    = pend_q ? bus.glb_r_data : rd_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d    = win_onehot;
          owner_d    = win_idx;
          addr_d     = win_addr;
          len_d      = (win_len == '0) ? LEN_BITWIDTH'(1) : win_len;
          read_req_d = 1'b1;
          cnt_d      = LEN_BITWIDTH'(1);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q < len_q) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          read_req_d = 1'b0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final beat is registered on this edge, so done rides with it.
        done_d   = grant_q;
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
        grant_d  = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= PTR_W'(REQ_IACT);
      owner_q      <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      read_req_q   <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_grant_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      read_req_q   <= read_req_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_grant_q <= pend_grant_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.glb_r_addr   = addr_q;
  assign bus.glb_read_req = read_req_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_glb_rd_arbiter.sv
// Bench for glb_rd_arbiter: directed scenarios plus random bursts, checked against
// a burst-level round-robin model with a timed return-beat scoreboard.
module tb_glb_rd_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  glb_rd_arbiter_if bus ();

  glb_rd_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // GLB model: synchronous read, data one cycle after the enable.
  logic [15:0] mem [1024];
  always @(posedge clk) if (bus.glb_read_req) bus.glb_r_data <= mem[bus.glb_r_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct { int t; int own; int data; bit last; } beat_t;
  beat_t sb[$];
  bit    m_busy = 0;
  int    m_rr = 0, m_own = 0, m_base = 0, m_len = 0, m_iss = 0, cyc = 0;
  bit    s_reset = 1'b1;
  logic [2:0] s_req = '0;
  int    s_addr [3];
  int    s_len  [3];

  function automatic int rr_pick(input logic [2:0] r, input int ptr);
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (ptr + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    bit idle_prev;
    int w;
    int a;
    beat_t e;
    cyc++;
    if (s_reset) begin
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_rd_req", 32'(bus.glb_read_req), 0);
      chk("rst_addr", 32'(bus.glb_r_addr), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_done", 32'(bus.done), 0);
      m_busy = 0;
      m_rr   = 0;
      sb.delete();
    end else begin
      idle_prev = !m_busy;
      if (sb.size() > 0 && sb[0].t == cyc) begin
        e = sb.pop_front();
        chk("rd_valid", 32'(bus.rd_valid), 1 << e.own);
        chk("rd_data", 32'(bus.rd_data), e.data);
        chk("done", 32'(bus.done), e.last ? (1 << e.own) : 0);
        if (e.last) begin
          m_busy = 0;
          m_rr   = (e.own + 1) % 3;
          chk("grant_clr", 32'(bus.grant), 0);
        end
      end else begin
        chk("rd_valid_quiet", 32'(bus.rd_valid), 0);
        chk("done_quiet", 32'(bus.done), 0);
      end
      if (idle_prev) begin
        w = rr_pick(s_req, m_rr);
        if (w < 0) chk("grant_none", 32'(bus.grant), 0);
        else begin
          chk("grant", 32'(bus.grant), 1 << w);
          m_busy = 1;
          m_own  = w;
          m_base = s_addr[w];
          m_len  = (s_len[w] == 0) ? 1 : s_len[w];
          m_iss  = 0;
        end
      end else if (m_busy) chk("grant_hold", 32'(bus.grant), 1 << m_own);
      if (m_busy && m_iss < m_len) begin
        a = (m_base + m_iss) % 1024;
        chk("rd_req", 32'(bus.glb_read_req), 1);
        chk("rd_addr", 32'(bus.glb_r_addr), a);
        e.t = cyc + 2; e.own = m_own; e.data = int'(mem[a]); e.last = (m_iss == m_len - 1);
        sb.push_back(e);
        m_iss++;
      end else chk("rd_req_off", 32'(bus.glb_read_req), 0);
    end
    s_reset = reset;
    s_req   = bus.req;
    for (int i = 0; i < 3; i++) begin
      s_addr[i] = int'((bus.req_addr >> (i*10)) & 30'h3FF);
      s_len[i]  = int'((bus.req_len >> (i*7)) & 21'h7F);
    end
  end

  // Stimulus.
  logic [2:0] auto_drop = 3'b111;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (((bus.done >> i) & 3'b001) != 0 && ((auto_drop >> i) & 3'b001) != 0)
        bus.req = bus.req & ~(3'b001 << i);
  endtask

  task automatic set_req(input int i, input int a, input int l);
    bus.req_addr = (bus.req_addr & ~(30'h3FF << (i*10))) | ((30'(a) & 30'h3FF) << (i*10));
    bus.req_len  = (bus.req_len & ~(21'h7F << (i*7))) | ((21'(l) & 21'h7F) << (i*7));
    bus.req      = bus.req | (3'b001 << i);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    step();
    while ((bus.req != 0 || bus.grant != 0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(bus.req | bus.grant), 0);
    repeat (2) step();
  endtask

  initial begin
    int n, nb;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    reset = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_len = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single long iact burst.
    set_req(0, 100, 25);
    wait_idle(200);

    // All three at once, rotating order.
    set_req(0, 10, 4); set_req(1, 500, 4); set_req(2, 900, 4);
    wait_idle(200);

    // Fairness between two persistent requesters.
    auto_drop = 3'b000;
    set_req(0, 40, 2); set_req(2, 60, 2);
    n = 0; nb = 0;
    while (nb < 4 && n < 200) begin
      step();
      if (bus.done != 0) nb++;
      n++;
    end
    chk("fair_timeout", 32'(nb), 4);
    bus.req = '0;
    auto_drop = 3'b111;
    wait_idle(200);

    // Address wrap, then zero-length burst, both on requester 1.
    set_req(1, 1022, 4);
    wait_idle(100);
    set_req(1, 77, 0);
    wait_idle(100);

    // Reset partway through a burst; pointer must restart at 0.
    set_req(2, 300, 10);
    n = 0; nb = 0;
    while (nb < 3 && n < 100) begin
      step();
      if (bus.rd_valid != 0) nb++;
      n++;
    end
    chk("beat_timeout", 32'(nb), 3);
    reset = 1'b1;
    bus.req = '0;
    step();
    reset = 1'b0;
    set_req(1, 200, 3); set_req(2, 250, 3);
    wait_idle(100);

    // Inputs change and req drops right after grant; burst still completes.
    set_req(0, 600, 8);
    n = 0;
    while (bus.grant == 0 && n < 20) begin step(); n++; end
    chk("grant_timeout", 32'(bus.grant), 1);
    bus.req = '0;
    bus.req_addr = 30'h1234567;
    bus.req_len  = 21'h0F0F0;
    wait_idle(100);

    // Random mixes.
    for (int r = 0; r < 30; r++) begin
      int mask;
      mask = $urandom_range(1, 7);
      for (int i = 0; i < 3; i++)
        if (((mask >> i) & 1) != 0) set_req(i, $urandom_range(0, 1023), $urandom_range(0, 20));
      wait_idle(300);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glb_rd_arbiter.md
Name: glb_rd_arbiter

Overview:
Round-robin arbiter and burst sequencer that shares the single global-buffer (GLB) read port among the PE-array routers (iact, weight, psum).
- A requester asks for a burst of consecutive GLB words.
- The arbiter grants one requester and drives the GLB read address/enable for the burst.
- It steers the one-cycle-late read data back to that requester with a valid strobe and a completion pulse.
- It sits between the routers and the GLB read port, replacing per-router direct GLB access.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = iact, 1 = weight, 2 = psum)
DATA_BITWIDTH, 16, GLB word width
ADDR_BITWIDTH_GLB, 10, GLB address width
LEN_BITWIDTH, 7, burst-length field width (max burst 2^LEN_BITWIDTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester burst request level
req_addr  in  NUM_REQ*ADDR_BITWIDTH_GLB  per-requester burst base address, packed, requester i at slice i
req_len  in  NUM_REQ*LEN_BITWIDTH  per-requester burst length in words, packed
grant  out  NUM_REQ  one-hot, current owner of the GLB port
glb_r_addr  out  ADDR_BITWIDTH_GLB  GLB read address
glb_read_req  out  1  GLB read enable
glb_r_data  in  DATA_BITWIDTH  GLB read data, valid one cycle after glb_read_req
rd_data  out  DATA_BITWIDTH  registered copy of glb_r_data
rd_valid  out  NUM_REQ  one-hot, rd_data valid for that requester
done  out  NUM_REQ  one-cycle pulse on the cycle the last word of a burst is valid

Behaviour:
- Reset values: grant=0, glb_r_addr=0, glb_read_req=0, rd_data=0, rd_valid=0, done=0, state=IDLE, rr_ptr=0, beat counter=0.
- Reset mid-burst: abort immediately, no done pulse, all outputs at reset values the next cycle.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any req is high, select the winner: first requester with req set, scanning from rr_ptr upward with wrap.
  - On the next edge: grant=onehot(winner); capture base address and length (length 0 treated as 1); glb_r_addr=base; glb_read_req=1; beat counter=1; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE:
  - One read per cycle.
  - If beat counter < len: glb_r_addr increments by 1, wrapping modulo 2^ADDR_BITWIDTH_GLB; counter increments.
  - Else: glb_read_req=0; go to DRAIN.
- Return data path (independent of state):
  - rd_data and rd_valid are registered from the previous cycle's glb_read_req/grant.
  - First rd_valid arrives 2 cycles after the grant edge.
  - Exactly len rd_valid beats per burst, back-to-back.
- DRAIN:
  - The final beat is returned in this cycle.
  - done[winner] pulses with the final rd_valid.
  - rr_ptr = winner+1 (wrap to 0 at NUM_REQ).
  - grant clears; return to IDLE.
- Requester protocol: hold req, req_addr and req_len stable until done.
  - Inputs are sampled only at grant; later changes are ignored.
  - req deasserted mid-burst: finish the burst normally (no abort).
  - After done, the requester drops req within 1 cycle or it re-requests.
- Back-to-back: minimum one IDLE cycle between bursts; grant is never held across bursts.
- Simultaneous requests are resolved by rr_ptr only. A continuously requesting client waits at most NUM_REQ-1 bursts.
- glb_read_req is never high while grant is 0.

Decomposition:
- Shared package: state encoding localparams (IDLE/ISSUE/DRAIN), requester index constants (REQ_IACT=0, REQ_WGHT=1, REQ_PSUM=2), default widths.
- One natural sub-module: rr_arbiter_pick. Purely combinational; takes req and rr_ptr and returns the one-hot winner and a found flag.

Test Plan:
1. Single iact burst: req=001, addr0=100, len0=25. Expected response:
   - glb_read_req high 25 cycles with addresses 100..124.
   - 25 rd_valid=001 beats with data matching the GLB model.
   - done[0] on the last beat; grant returns to 0.
2. Simultaneous requests: req=111, all len=4, rr_ptr=0. Expected response:
   - Grants in order 001, 010, 100, each burst 4 beats with one IDLE cycle between.
   - done pulses in the same order.
3. Fairness: requesters 0 and 2 held continuously, len=2. Expected response: grants alternate 001, 100, 001, 100; requester 1 is never granted.
4. Address wrap and zero length: addr=1022, len=4 gives addresses 1022, 1023, 0, 1. A separate burst with len=0 produces exactly 1 read and 1 done.
5. Reset mid-burst: assert reset on the 3rd beat of a len=10 burst. Expected response:
   - Next cycle all outputs are 0 with no done.
   - After reset releases, a new req=010 is granted with rr_ptr=0 behaviour.
6. req dropped mid-burst and inputs changed after grant: the burst completes with the originally captured addr/len and done still pulses.
